// File: rtl/stack_pkg.sv
// stack_pkg: opcode and FSM state types plus the capacity helper shared by
// the operand-stack controller and its bench.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Total entries the stack can hold: every RAM word plus the tos register.
  function automatic int unsigned stack_capacity(input int unsigned awidth);
    return (32'd1 << awidth) + 32'd1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// stack_ram: single-port spill memory, synchronous write, registered read.
// A read and a write to the same address in one cycle return the old word.
module stack_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Write at the edge; read data is registered and valid the following cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: operand-stack sequencer. tos lives in a register, deeper
// entries spill into stack_ram. POP (depth >= 2), ADD and SUB take a second
// FILL cycle to pull the next entry back out of the RAM.
// Optional feature macro: STACK_CTRL_ARITH_EN builds ADD/SUB; without it
// opcodes 4 and 5 are rejected as illegal.
//
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. Every accepted
// command produces exactly one done pulse (with err for a rejection), unless
// rst aborts it. cmd_op/cmd_data only need to be stable while cmd_valid is
// high and cmd_ready is being waited on.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DWIDTH-1:0] cmd_data,
  output logic [DWIDTH-1:0] tos,
  output logic [AWIDTH:0]   count,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic              underflow,
  output state_t            dbg_state
);

  localparam int              CW  = AWIDTH + 1;
  localparam logic [AWIDTH:0] CAP = CW'(stack_capacity(AWIDTH));

  state_t            state;
  op_e               op;
  logic              accept;
  logic              is_push;
  logic [AWIDTH:0]   sp;
  logic [DWIDTH-1:0] push_val;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_rdata;

`ifdef STACK_CTRL_ARITH_EN
  op_e               fill_op;
`endif

  assign op        = op_e'(cmd_op);
  assign accept    = cmd_valid && (state == ST_IDLE);
  assign is_push   = (op == OP_PUSH) || (op == OP_DUP);
  assign sp        = (count == '0) ? '0 : count - CW'(1);
  assign push_val  = (op == OP_DUP) ? tos : cmd_data;
  assign cmd_ready = (state == ST_IDLE);
  assign dbg_state = state;

  // Spill tos into the next free slot when a push lands on a non-empty,
  // non-full stack; otherwise keep the address on the entry below tos so a
  // FILL command has its read data one cycle later.
  assign ram_we   = accept && is_push && (count != '0) && (count != CAP);
  assign ram_addr = is_push ? AWIDTH'(sp) : AWIDTH'(sp - CW'(1));

  stack_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (tos),
    .rdata (ram_rdata)
  );

  // Command FSM: decode in IDLE, finish the read-modify-write in FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tos       <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef STACK_CTRL_ARITH_EN
      fill_op   <= OP_NOP;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op)
              OP_NOP: begin
                done <= 1'b1;
              end
              OP_PUSH, OP_DUP: begin
                done <= 1'b1;
                if ((op == OP_DUP) && (count == '0)) begin
                  err       <= 1'b1;
                  underflow <= 1'b1;
                end else if (count == CAP) begin
                  err      <= 1'b1;
                  overflow <= 1'b1;
                end else begin
                  tos   <= push_val;
                  count <= count + CW'(1);
                end
              end
              OP_POP: begin
                if (count == '0) begin
                  done      <= 1'b1;
                  err       <= 1'b1;
                  underflow <= 1'b1;
                end else if (count == CW'(1)) begin
                  done  <= 1'b1;
                  tos   <= '0;
                  count <= '0;
                end else begin
                  state <= ST_FILL;
`ifdef STACK_CTRL_ARITH_EN
                  fill_op <= op;
`endif
                end
              end
`ifdef STACK_CTRL_ARITH_EN
              OP_ADD, OP_SUB: begin
                if (count < CW'(2)) begin
                  done      <= 1'b1;
                  err       <= 1'b1;
                  underflow <= 1'b1;
                end else begin
                  state   <= ST_FILL;
                  fill_op <= op;
                end
              end
`endif
              default: begin
                done <= 1'b1;
                err  <= 1'b1;
              end
            endcase
          end
        end
        ST_FILL: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          count <= count - CW'(1);
`ifdef STACK_CTRL_ARITH_EN
          case (fill_op)
            OP_ADD:  tos <= ram_rdata + tos;
            OP_SUB:  tos <= ram_rdata - tos;
            default: tos <= ram_rdata;
          endcase
`else
          tos <= ram_rdata;
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the operand stack of the stack CPU. It accepts one stack command at a time from the instruction controller and keeps the top-of-stack in a register (`tos`). Entries below the top spill into a single-port synchronous RAM. It tracks depth, reports overflow and underflow, and runs the two-cycle read-modify-write sequences that pop and arithmetic commands need.

## Interface
- `DWIDTH`, 16, stack word width
- `AWIDTH`, 4, RAM address width. RAM holds 2**AWIDTH words; total capacity is 2**AWIDTH+1 including `tos`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller idle; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_op` input 3: opcode, decoded from `stack_pkg`.
- `cmd_data` input DWIDTH: PUSH operand; ignored for other opcodes.
- `tos` output DWIDTH: current top of stack.
- `count` output AWIDTH+1: number of valid entries.
- `done` output 1: one-cycle pulse when a command has completed.
- `err` output 1: one-cycle pulse, coincident with `done`, when the command was rejected.
- `overflow`, `underflow` output 1: sticky error flags; only `rst` clears them.

## Operation
- Opcodes:
  - 0 NOP: no-op.
  - 1 PUSH: push `cmd_data`.
  - 2 POP: remove top.
  - 3 DUP: push copy of `tos`.
  - 4 ADD: new `tos` = next + `tos`, depth −1.
  - 5 SUB: new `tos` = next − `tos`, depth −1.
  - 6, 7 illegal: `err` pulse; no flags set, no state change.
- Internal `sp` (AWIDTH+1 bits) = `count`−1 when `count`≥1, else 0. It is the next free RAM slot.
- The RAM holds entries 0..`count`−2; `tos` holds entry `count`−1.
- PUSH, DUP (1 cycle):
  - If `count`==0: `tos`←value, `count`←1, no RAM write.
  - Else: write `tos` to RAM[`sp`], `tos`←value, `count`+1.
  - If `count`==2**AWIDTH+1: reject, set `overflow`.
  - DUP with `count`==0: reject, set `underflow`.
- POP:
  - If `count`==1: 1 cycle, `tos`←0, `count`←0.
  - If `count`≥2: issue a read of RAM[`sp`−1] and enter state FILL. On the next edge, `tos`←read data and `count`−1.
  - If `count`==0: reject, set `underflow`.
- ADD/SUB:
  - Require `count`≥2, else reject and set `underflow`.
  - Read RAM[`sp`−1], enter FILL. On the next edge, `tos`←op(rdata, `tos`) and `count`−1.
  - Arithmetic is modulo 2**DWIDTH; no carry or borrow output.
- NOP: 1 cycle, `done` only.
- Rejected commands: 1 cycle; `tos` and `count` unchanged; `done` and `err` pulse together.
- FSM states:
  - IDLE: `cmd_ready`=1. An accepted 1-cycle command stays in IDLE. An accepted POP/ADD/SUB with `count`≥2 goes to FILL.
  - FILL: `cmd_ready`=0. Always returns to IDLE on the next edge.

## Timing
- Reset values: `tos`=0, `count`=0, `sp`=0, `cmd_ready`=1, `done`=0, `err`=0, `overflow`=0, `underflow`=0, state IDLE.
- `rst` wins over any other input on the same edge.
- `rst` during FILL aborts the pending read; no `done` is produced.
- RAM: write takes effect at the edge. Read data is registered and valid in the cycle after the address.
- Latency, command accepted at edge N:
  - 1-cycle commands: `done` high in cycle N+1; `tos`/`count` updated at edge N.
  - FILL commands: `done` high in cycle N+2; `tos`/`count` updated at edge N+1.
- Throughput: 1-cycle commands can issue back-to-back every cycle. FILL commands block for one extra cycle.
- `tos`, `count`, `done`, `err` and the flags are all registered outputs.

## Configuration
- `STACK_CTRL_ARITH_EN` defined: ADD and SUB behave as above.
- Undefined: the adder/subtractor is not built. Opcodes 4 and 5 are treated as illegal: `err` pulse, no state change, no flag set.

## Structure
- `stack_pkg` holds:
  - the opcode enum (`OP_NOP`, `OP_PUSH`, `OP_POP`, `OP_DUP`, `OP_ADD`, `OP_SUB`);
  - the FSM state type (`ST_IDLE`, `ST_FILL`);
  - the capacity constant function of AWIDTH.
- One sub-module, `stack_ram`: single port, AWIDTH×DWIDTH, synchronous write, registered read. It is instantiated once inside `stack_ctrl`.

## Test plan
- Reset then PUSH 0x0011, PUSH 0x0022, ADD → `done` 1 cycle after each PUSH and 2 cycles after ADD; final `tos`=0x0033, `count`=1.
- PUSH 0x0005, PUSH 0x0007, SUB → `tos`=0xFFFE (wrap), `count`=1. With `STACK_CTRL_ARITH_EN` undefined, SUB instead gives `err`, `tos`=0x0007, `count`=2.
- With AWIDTH=2, push 1..5 → `count`=5, `tos`=5. Sixth PUSH → `err`, `overflow`=1, state unchanged. Five POPs return `tos` 4,3,2,1, then 0 with `count`=0.
- POP on empty, then ADD with `count`=1 → `err` pulses each time, `underflow`=1 and stays set through later successful commands.
- Back-to-back PUSH on consecutive cycles with `cmd_valid` held high; ADD deasserts `cmd_ready` for exactly one cycle; DUP of 0x00AA → `count`+1, both top entries 0xAA, verified by POP.
- Assert `rst` in the FILL cycle of a POP → no `done`; next cycle all outputs at reset values, `cmd_ready`=1.
